// File: rtl/d5m_capture_stream_if.sv
// Avalon-ST source interface carrying captured D5M pixels to the frame writer.
// master = capture front end (drives data/valid/sop/eop), slave = consumer (drives ready).
interface d5m_capture_stream_if #(
    parameter int unsigned DATA_W = 12
) ();

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );

endinterface

// File: rtl/d5m_capture_stream.sv
// D5M pixel-port capture front end: synchronises FVAL/LVAL/DATA, frames COLS x LINES pixels
// into Avalon-ST packets (SOP/EOP) and buffers them in a show-ahead FIFO with backpressure.
// Supports continuous capture or single-shot (one frame, then disarmed until enable drops).
module d5m_capture_stream #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned COLS        = 2592,
    parameter int unsigned LINES       = 1944,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  single_shot,
    input  logic                  frame_valid,
    input  logic                  line_valid,
    input  logic [DATA_W-1:0]     data_in,
    d5m_capture_stream_if.master  st,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  overflow_err,
    output logic                  short_err
);

    localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned LineW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [ColW-1:0]  ColLast  = ColW'(COLS - 1);
    localparam logic [LineW-1:0] LineLast = LineW'(LINES - 1);
    localparam logic [CntW-1:0]  FifoFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StArmed, StFrame, StDone} state_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] fv_sync_q;
    logic [SYNC_STAGES-1:0] lv_sync_q;
    logic [DATA_W-1:0]      d_sync_q [SYNC_STAGES];
    logic                   fv_prev_q;
    logic                   enable_q;

    logic              fv_s;
    logic              lv_s;
    logic [DATA_W-1:0] d_s;
    logic              fv_rise;

    assign fv_s    = fv_sync_q[SYNC_STAGES-1];
    assign lv_s    = lv_sync_q[SYNC_STAGES-1];
    assign d_s     = d_sync_q[SYNC_STAGES-1];
    assign fv_rise = fv_s & ~fv_prev_q;

    // Shift the asynchronous sensor pins through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_sync_q <= '0;
            lv_sync_q <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                d_sync_q[i] <= '0;
            end
            fv_prev_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            fv_sync_q   <= {fv_sync_q[SYNC_STAGES-2:0], frame_valid};
            lv_sync_q   <= {lv_sync_q[SYNC_STAGES-2:0], line_valid};
            d_sync_q[0] <= data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                d_sync_q[i] <= d_sync_q[i-1];
            end
            fv_prev_q <= fv_s;
            enable_q  <= enable;
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ColW-1:0]    col_q, col_d;
    logic [LineW-1:0]   line_q, line_d;
    logic               ss_q, ss_d;
    // Set once a single-shot frame has completed; keeps IDLE from re-arming until enable drops.
    logic               ss_done_q, ss_done_d;
    // Line already has COLS pixels; further LVAL is ignored until it falls.
    logic               line_full_q, line_full_d;
    logic               pushed_q, pushed_d;
    logic [15:0]        fcount_q, fcount_d;
    logic               short_set;

    logic               push_valid;
    logic [DATA_W-1:0]  push_data;
    logic               push_sop;
    logic               push_eop;

    // Advance the framing state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            line_q      <= '0;
            ss_q        <= 1'b0;
            ss_done_q   <= 1'b0;
            line_full_q <= 1'b0;
            pushed_q    <= 1'b0;
            fcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            ss_q        <= ss_d;
            ss_done_q   <= ss_done_d;
            line_full_q <= line_full_d;
            pushed_q    <= pushed_d;
            fcount_q    <= fcount_d;
        end
    end

    // Next-state logic and pixel push request generation.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        ss_d        = ss_q;
        ss_done_d   = ss_done_q;
        line_full_d = line_full_q;
        pushed_d    = pushed_q;
        fcount_d    = fcount_q;
        short_set   = 1'b0;
        push_valid  = 1'b0;
        push_data   = '0;
        push_sop    = 1'b0;
        push_eop    = 1'b0;

        if (!enable) begin
            ss_done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (enable && !ss_done_q) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (fv_rise) begin
                    ss_d        = single_shot;
                    col_d       = '0;
                    line_d      = '0;
                    line_full_d = 1'b0;
                    pushed_d    = 1'b0;
                    state_d     = StFrame;
                end
            end
            StFrame: begin
                if (!lv_s) begin
                    line_full_d = 1'b0;
                end
                if (!fv_s) begin
                    // Frame cut short: close the packet with a filler EOP if one was opened.
                    short_set = 1'b1;
                    if (pushed_q) begin
                        push_valid = 1'b1;
                        push_eop   = 1'b1;
                    end
                    state_d = StDone;
                end else if (lv_s && !line_full_q) begin
                    push_valid = 1'b1;
                    push_data  = d_s;
                    push_sop   = (col_q == '0) && (line_q == '0);
                    push_eop   = (col_q == ColLast) && (line_q == LineLast);
                    pushed_d   = 1'b1;
                    if (col_q == ColLast) begin
                        col_d       = '0;
                        line_d      = line_q + LineW'(1);
                        line_full_d = 1'b1;
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                    if (push_eop) begin
                        fcount_d = fcount_q + 16'd1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (!fv_s) begin
                    if (ss_q || !enable) begin
                        state_d = StIdle;
                        if (ss_q && enable) begin
                            ss_done_d = 1'b1;
                        end
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Push pipeline register and output FIFO
    // ------------------------------------------------------------------
    logic              wr_valid_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_sop_q;
    logic              wr_eop_q;

    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              eop_pend_q, eop_pend_d;

    logic              fifo_full;
    logic              pop;
    logic              can_write;
    logic              fifo_we;
    logic [DATA_W-1:0] we_data;
    logic              we_sop;
    logic              we_eop;
    logic              ovf_set;
    logic [DATA_W+1:0] rd_word;

    assign fifo_full = (count_q == FifoFull);
    assign pop       = st.out_valid & st.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign can_write = !fifo_full || pop;

    // Register push requests one cycle before the FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_sop_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
        end else begin
            wr_valid_q <= push_valid;
            wr_data_q  <= push_data;
            wr_sop_q   <= push_sop;
            wr_eop_q   <= push_eop;
        end
    end

    // Decide what gets written; a dropped EOP is kept pending so the packet still terminates.
    always_comb begin
        fifo_we    = 1'b0;
        we_data    = '0;
        we_sop     = 1'b0;
        we_eop     = 1'b0;
        eop_pend_d = eop_pend_q;
        ovf_set    = 1'b0;
        if (wr_valid_q) begin
            if (can_write) begin
                fifo_we    = 1'b1;
                we_data    = wr_data_q;
                we_sop     = wr_sop_q;
                we_eop     = wr_eop_q | eop_pend_q;
                eop_pend_d = 1'b0;
            end else begin
                ovf_set = 1'b1;
                if (wr_eop_q) begin
                    eop_pend_d = 1'b1;
                end
            end
        end else if (eop_pend_q && can_write) begin
            fifo_we    = 1'b1;
            we_eop     = 1'b1;
            eop_pend_d = 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem_q[wr_ptr_q] <= {we_sop, we_eop, we_data};
        end
    end

    // FIFO pointers, occupancy and pending-EOP flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            eop_pend_q <= 1'b0;
        end else begin
            eop_pend_q <= eop_pend_d;
            if (fifo_we) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (fifo_we && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!fifo_we && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Sticky error flags, cleared on the falling edge of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
            short_err    <= 1'b0;
        end else if (enable_q && !enable) begin
            overflow_err <= 1'b0;
            short_err    <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end
            if (short_set) begin
                short_err <= 1'b1;
            end
        end
    end

    assign rd_word      = mem_q[rd_ptr_q];
    assign st.out_valid = (count_q != '0);
    assign st.out_data  = st.out_valid ? rd_word[DATA_W-1:0] : '0;
    assign st.out_eop   = st.out_valid & rd_word[DATA_W];
    assign st.out_sop   = st.out_valid & rd_word[DATA_W+1];
    assign busy         = (state_q != StIdle);
    assign frame_count  = fcount_q;

endmodule

// File: tb/tb_d5m_capture_stream.sv
// Directed bench for d5m_capture_stream with COLS=4, LINES=3, FIFO_DEPTH=4, DATA_W=12.
module tb_d5m_capture_stream;

    localparam int DW    = 12;
    localparam int COLS  = 4;
    localparam int LINES = 3;
    localparam int SS    = 2;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          single_shot = 1'b0;
    logic          frame_valid = 1'b0;
    logic          line_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          busy;
    logic [15:0]   frame_count;
    logic          overflow_err;
    logic          short_err;

    d5m_capture_stream_if #(.DATA_W(DW)) st_if ();

    d5m_capture_stream #(
        .DATA_W     (DW),
        .COLS       (COLS),
        .LINES      (LINES),
        .SYNC_STAGES(SS),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .single_shot (single_shot),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .data_in     (data_in),
        .st          (st_if),
        .busy        (busy),
        .frame_count (frame_count),
        .overflow_err(overflow_err),
        .short_err   (short_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] beats[$];
    logic [13:0] exp_q[$];
    bit          seen_valid = 1'b0;
    bit          lv_seen = 1'b0;
    int          first_valid_cyc = 0;
    int          lv_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Record accepted beats as {sop, eop, data}, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && st_if.out_valid) begin
            if (!seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (st_if.out_ready)
                beats.push_back({st_if.out_sop, st_if.out_eop, st_if.out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One sensor frame: lv_len LVAL clocks per line, data base+line*COLS+col,
    // optionally cut (FVAL/LVAL low) once cut_after pixels have been sent.
    task automatic sensor_frame(input int lv_len, input int cut_after, input int base);
        int pix;
        pix = 0;
        frame_valid = 1'b1;
        repeat (3) tick();
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < lv_len; c++) begin
                if (cut_after >= 0 && pix == cut_after) begin
                    line_valid  = 1'b0;
                    frame_valid = 1'b0;
                    data_in     = '0;
                    repeat (8) tick();
                    return;
                end
                line_valid = 1'b1;
                if (!lv_seen) begin
                    lv_seen = 1'b1;
                    lv_cyc  = cyc;
                end
                if (c < COLS) begin
                    data_in = DW'(base + l * COLS + c);
                    pix++;
                end else begin
                    data_in = '1;
                end
                tick();
            end
            line_valid = 1'b0;
            data_in    = '0;
            repeat (3) tick();
        end
        frame_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic push_ramp(input int base);
        for (int i = 0; i < COLS * LINES; i++)
            exp_q.push_back({(i == 0), (i == COLS * LINES - 1), DW'(base + i)});
    endtask

    task automatic check_beats(input string tag);
        logic [31:0] g;
        check({tag, "_count"}, beats.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < beats.size()) g = 32'(beats[i]);
            else g = 32'hFFFF_FFFF;
            check(tag, g, 32'(exp_q[i]));
        end
        exp_q.delete();
        beats.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        single_shot = 1'b0;
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        data_in     = '0;
        st_if.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        beats.delete();
        exp_q.delete();
        seen_valid = 1'b0;
        lv_seen    = 1'b0;
        tick();
    endtask

    initial begin
        st_if.out_ready = 1'b1;
        repeat (3) tick();
        // Reset state
        check("rst_valid", st_if.out_valid, 0);
        check("rst_data", st_if.out_data, 0);
        check("rst_sop_eop", {st_if.out_sop, st_if.out_eop}, 0);
        check("rst_busy", busy, 0);
        check("rst_fcount", frame_count, 0);
        check("rst_errs", {overflow_err, short_err}, 0);

        // 1: continuous ramp frame
        do_reset();
        enable = 1'b1;
        repeat (3) tick();
        check("t1_busy_armed", busy, 1);
        sensor_frame(4, -1, 0);
        repeat (10) tick();
        push_ramp(0);
        check_beats("t1_beat");
        check("t1_fcount", frame_count, 1);
        check("t1_latency", first_valid_cyc - lv_cyc, SS + 2);
        check("t1_busy", busy, 1);
        check("t1_errs", {overflow_err, short_err}, 0);

        // 2: single shot, two sensor frames
        do_reset();
        enable      = 1'b1;
        single_shot = 1'b1;
        repeat (3) tick();
        sensor_frame(4, -1, 100);
        check("t2_busy_after", busy, 0);
        sensor_frame(4, -1, 200);
        repeat (10) tick();
        push_ramp(100);
        check_beats("t2_beat");
        check("t2_fcount", frame_count, 1);
        check("t2_busy", busy, 0);

        // 3: armed mid-frame, that frame skipped
        do_reset();
        fork
            sensor_frame(4, -1, 300);
            begin
                repeat (8) tick();
                enable = 1'b1;
            end
        join
        sensor_frame(4, -1, 400);
        repeat (10) tick();
        push_ramp(400);
        check_beats("t3_beat");
        check("t3_fcount", frame_count, 1);

        // 4: FVAL drops after 7 pixels
        do_reset();
        enable = 1'b1;
        repeat (3) tick();
        sensor_frame(4, 7, 0);
        repeat (10) tick();
        for (int i = 0; i < 7; i++) exp_q.push_back({(i == 0), 1'b0, DW'(i)});
        exp_q.push_back({1'b0, 1'b1, 12'd0});
        check_beats("t4_beat");
        check("t4_short", short_err, 1);
        check("t4_ovf", overflow_err, 0);
        check("t4_fcount", frame_count, 0);
        enable = 1'b0;
        repeat (2) tick();
        check("t4_short_clr", short_err, 0);

        // 5: no ready for the whole frame
        do_reset();
        st_if.out_ready = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        sensor_frame(4, -1, 0);
        repeat (4) tick();
        check("t5_held_none", beats.size(), 0);
        check("t5_valid", st_if.out_valid, 1);
        check("t5_ovf", overflow_err, 1);
        check("t5_fcount", frame_count, 1);
        st_if.out_ready = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < FD; i++) exp_q.push_back({(i == 0), 1'b0, DW'(i)});
        exp_q.push_back({1'b0, 1'b1, 12'd0});
        check_beats("t5_beat");
        check("t5_empty", st_if.out_valid, 0);

        // 6: long LVAL, then async reset mid-frame
        do_reset();
        enable = 1'b1;
        repeat (3) tick();
        sensor_frame(6, -1, 0);
        repeat (10) tick();
        push_ramp(0);
        check_beats("t6_lv");
        check("t6_fcount", frame_count, 1);
        fork
            sensor_frame(4, -1, 500);
            begin
                repeat (18) tick();
                #3 rst_n = 1'b0;
                #1;
                check("t6_rst_valid", st_if.out_valid, 0);
                check("t6_rst_busy", busy, 0);
                check("t6_rst_fcount", frame_count, 0);
                check("t6_rst_flags", {st_if.out_sop, st_if.out_eop, st_if.out_data}, 0);
            end
        join
        tick();
        rst_n = 1'b1;
        beats.delete();
        repeat (3) tick();
        sensor_frame(4, -1, 600);
        repeat (10) tick();
        push_ramp(600);
        check_beats("t6_after");
        check("t6_after_fcount", frame_count, 1);
        check("t6_after_errs", {overflow_err, short_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
